// File: rtl/airhockey_pixel_renderer.sv
// Air-hockey pixel stage: turns LCD timing counters into registered RGB for the
// playfield, puck and two mallets, with once-per-frame double-buffered positions.
module airhockey_pixel_renderer #(
  parameter int FIELD_W  = 800,
  parameter int FIELD_H  = 480,
  parameter int BORDER   = 8,
  parameter int PUCK_R   = 12,
  parameter int MALLET_R = 20,
  parameter int LAT      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] disp_col,
  input  logic [10:0] disp_row,
  input  logic        visible_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [11:0] wr_x,
  input  logic [10:0] wr_y,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        frame_latched
);

  localparam logic [11:0] INIT_X [3] = '{12'd400, 12'd100, 12'd700};
  localparam logic [10:0] INIT_Y [3] = '{11'd240, 11'd240, 11'd240};
  localparam logic [26:0] R2 [3] = '{27'(PUCK_R * PUCK_R), 27'(MALLET_R * MALLET_R),
                                     27'(MALLET_R * MALLET_R)};

  localparam logic [23:0] C_BLACK  = 24'h000000;
  localparam logic [23:0] C_PUCK   = 24'hFFD700;
  localparam logic [23:0] C_MAL_A  = 24'hE02020;
  localparam logic [23:0] C_MAL_B  = 24'h2040E0;
  localparam logic [23:0] C_BORDER = 24'hFFFFFF;
  localparam logic [23:0] C_CENTRE = 24'hA0A0A0;
  localparam logic [23:0] C_BG     = 24'h004020;

  // Object index 0 = puck, 1 = mallet A, 2 = mallet B.
  logic [11:0] sh_x [3];
  logic [10:0] sh_y [3];
  logic [11:0] act_x [3];
  logic [10:0] act_y [3];
  logic        vs_prev;
  logic        pending;
  logic        trigger;
  logic        wr_valid;

  assign trigger  = vs_prev & ~vs_in;
  assign wr_valid = wr_en & (wr_sel != 2'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sh_x[i]  <= INIT_X[i];
        sh_y[i]  <= INIT_Y[i];
        act_x[i] <= INIT_X[i];
        act_y[i] <= INIT_Y[i];
      end
      vs_prev       <= 1'b1;
      pending       <= 1'b0;
      frame_latched <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the latch copy the shadow values from
      // before this clock, so a write landing on the vsync edge waits a frame.
      vs_prev       <= vs_in;
      frame_latched <= trigger;
      // With nothing pending the shadow already equals the active set.
      if (trigger && pending) begin
        for (int i = 0; i < 3; i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (wr_valid && wr_sel == 2'(i)) begin
          sh_x[i] <= wr_x;
          sh_y[i] <= wr_y;
        end
      end
      if (wr_valid) pending <= 1'b1;
      else if (trigger) pending <= 1'b0;
    end
  end

  // Stage 1: signed offsets and field flags.
  logic signed [12:0] dx_q [3];
  logic signed [12:0] dy_q [3];
  logic               border_q1, centre_q1;
  // Stage 2: squared distances.
  logic [26:0]        dist_q [3];
  logic               border_q2, centre_q2;
  logic signed [25:0] sq_x [3];
  logic signed [25:0] sq_y [3];
  // Sync/enable delay lines, oldest sample in the top bit.
  logic [LAT-1:0]     de_pipe, hs_pipe, vs_pipe;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sq_x[i] = dx_q[i] * dx_q[i];
      sq_y[i] = dy_q[i] * dy_q[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        dx_q[i]   <= '0;
        dy_q[i]   <= '0;
        dist_q[i] <= '0;
      end
      border_q1 <= 1'b0;
      centre_q1 <= 1'b0;
      border_q2 <= 1'b0;
      centre_q2 <= 1'b0;
      de_pipe   <= '0;
      hs_pipe   <= '0;
      vs_pipe   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        dx_q[i]   <= $signed({1'b0, disp_col}) - $signed({1'b0, act_x[i]});
        dy_q[i]   <= $signed({2'b0, disp_row}) - $signed({2'b0, act_y[i]});
        dist_q[i] <= {1'b0, sq_x[i]} + {1'b0, sq_y[i]};
      end
      border_q1 <= (disp_col < 12'(BORDER)) || (disp_col >= 12'(FIELD_W - BORDER)) ||
                   (disp_row < 11'(BORDER)) || (disp_row >= 11'(FIELD_H - BORDER));
      centre_q1 <= (disp_col == 12'(FIELD_W / 2 - 1)) || (disp_col == 12'(FIELD_W / 2));
      border_q2 <= border_q1;
      centre_q2 <= centre_q1;
      de_pipe   <= {de_pipe[LAT-2:0], visible_in};
      hs_pipe   <= {hs_pipe[LAT-2:0], hs_in};
      vs_pipe   <= {vs_pipe[LAT-2:0], vs_in};
    end
  end

  // Stage 3: hit tests and colour priority.
  logic [23:0] rgb_next;
  always_comb begin
    rgb_next = C_BG;
    if (!de_pipe[LAT-2])       rgb_next = C_BLACK;
    else if (dist_q[0] <= R2[0]) rgb_next = C_PUCK;
    else if (dist_q[1] <= R2[1]) rgb_next = C_MAL_A;
    else if (dist_q[2] <= R2[2]) rgb_next = C_MAL_B;
    else if (border_q2)        rgb_next = C_BORDER;
    else if (centre_q2)        rgb_next = C_CENTRE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      red   <= 8'd0;
      green <= 8'd0;
      blue  <= 8'd0;
    end else begin
      {red, green, blue} <= rgb_next;
    end
  end

  assign de_out = de_pipe[LAT-1];
  assign hs_out = hs_pipe[LAT-1];
  assign vs_out = vs_pipe[LAT-1];

endmodule

// File: tb/tb_airhockey_pixel_renderer.sv
// Scoreboard bench for airhockey_pixel_renderer: a behavioural model predicts each
// pixel and sync sample, queued at drive time and compared three clocks later.
module tb_airhockey_pixel_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] disp_col;
  logic [10:0] disp_row;
  logic        visible_in, hs_in, vs_in;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [11:0] wr_x;
  logic [10:0] wr_y;
  logic [7:0]  red, green, blue;
  logic        de_out, hs_out, vs_out, frame_latched;

  airhockey_pixel_renderer dut (
    .clock(clock), .reset(reset), .disp_col(disp_col), .disp_row(disp_row),
    .visible_in(visible_in), .hs_in(hs_in), .vs_in(vs_in), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y), .red(red), .green(green),
    .blue(blue), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .frame_latched(frame_latched)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [26:0] exp;   // {rgb, de, hs, vs}
    int          want;  // fixed colour demanded by the test plan, -1 if none
  } item_t;

  item_t q[$];
  string tq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state.
  int m_sx [3], m_sy [3], m_ax [3], m_ay [3];
  bit m_vs_prev;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = '{400, 100, 700};
    m_sy = '{240, 240, 240};
    m_ax = m_sx;
    m_ay = m_sy;
    m_vs_prev = 1'b1;
  endtask

  function automatic bit inside_r(int col, int row, int k, int r);
    int dx, dy;
    dx = col - m_ax[k];
    dy = row - m_ay[k];
    return (dx * dx + dy * dy) <= r * r;
  endfunction

  function automatic logic [23:0] ref_colour(int col, int row, bit vis);
    if (!vis) return 24'h000000;
    if (inside_r(col, row, 0, 12)) return 24'hFFD700;
    if (inside_r(col, row, 1, 20)) return 24'hE02020;
    if (inside_r(col, row, 2, 20)) return 24'h2040E0;
    if (col < 8 || col >= 792 || row < 8 || row >= 472) return 24'hFFFFFF;
    if (col == 399 || col == 400) return 24'hA0A0A0;
    return 24'h004020;
  endfunction

  // One pixel clock: drive, predict, clock, then check whatever has emerged.
  task automatic cyc(string tag, int col, int row, bit vis, bit hs, bit vs,
                     bit we = 1'b0, int sel = 0, int wx = 0, int wy = 0, int want = -1);
    item_t it;
    bit trig;
    disp_col = 12'(col); disp_row = 11'(row);
    visible_in = vis; hs_in = hs; vs_in = vs;
    wr_en = we; wr_sel = 2'(sel); wr_x = 12'(wx); wr_y = 11'(wy);
    it.exp  = {ref_colour(col, row, vis), vis, hs, vs};
    it.want = want;
    q.push_back(it);
    tq.push_back(tag);
    @(posedge clock);
    trig = m_vs_prev && !vs;
    if (trig) begin
      m_ax = m_sx;
      m_ay = m_sy;
    end
    if (we && sel < 3) begin
      m_sx[sel] = wx;
      m_sy[sel] = wy;
    end
    m_vs_prev = vs;
    #1;
    check("frame_latched", {31'd0, frame_latched}, {31'd0, trig});
    if (q.size() == 3) begin
      item_t o;
      string t;
      o = q.pop_front();
      t = tq.pop_front();
      check(t, {5'd0, red, green, blue, de_out, hs_out, vs_out}, {5'd0, o.exp});
      if (o.want >= 0) check({t, "_rgb"}, {8'd0, red, green, blue}, o.want);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check(tag, {25'd0, red, green, blue, de_out, hs_out, vs_out, frame_latched}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    disp_col = '0; disp_row = '0; visible_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    wr_en = 1'b0; wr_sel = '0; wr_x = '0; wr_y = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_outputs");
    reset = 1'b0;

    cyc("first_puck", 400, 240, 1, 1, 1, .want(32'hFFD700));

    // Random sync/enable patterns and pixel positions.
    for (int i = 0; i < 24; i++)
      cyc("align", $urandom_range(799), $urandom_range(479), 1'($urandom),
          1'($urandom), 1'($urandom));
    cyc("align_idle", 0, 0, 0, 1, 1);

    // Radius boundary around the puck at (400,240).
    cyc("r12", 412, 240, 1, 1, 1, .want(32'hFFD700));
    cyc("r12_left", 388, 240, 1, 1, 1, .want(32'hFFD700));
    cyc("r13", 413, 240, 1, 1, 1, .want(32'h004020));
    cyc("r_diag", 408, 249, 1, 1, 1, .want(32'h004020));

    // Double buffering: write mid-frame, visible only after vsync falls.
    cyc("db_write", 10, 10, 1, 1, 1, 1, 0, 200, 100);
    cyc("db_before", 200, 100, 1, 1, 1, .want(32'h004020));
    cyc("db_vsync", 0, 0, 0, 1, 0);
    cyc("db_after", 200, 100, 1, 1, 1, .want(32'hFFD700));

    // Write on the same clock as the vsync fall goes to the next frame.
    cyc("co_vs_hi", 0, 0, 0, 1, 1);
    cyc("co_vsync_wr", 0, 0, 0, 1, 0, 1, 2, 600, 300);
    cyc("co_new_old", 600, 300, 1, 1, 1, .want(32'h004020));
    cyc("co_old_pos", 700, 240, 1, 1, 1, .want(32'h2040E0));
    cyc("co_vsync2", 0, 0, 0, 1, 0);
    cyc("co_new_pos", 600, 300, 1, 1, 1, .want(32'h2040E0));

    // Priority: mallet over border, border, centre line, puck over mallet.
    cyc("pr_write_a", 0, 0, 0, 1, 1, 1, 1, 5, 5);
    cyc("pr_vsync", 0, 0, 0, 1, 0);
    cyc("pr_mallet_border", 5, 5, 1, 1, 1, .want(32'hE02020));
    cyc("pr_border", 0, 100, 1, 1, 1, .want(32'hFFFFFF));
    cyc("pr_centre", 399, 100, 1, 1, 1, .want(32'hA0A0A0));
    cyc("pr_write_p", 0, 0, 0, 1, 1, 1, 0, 5, 5);
    cyc("pr_vsync2", 0, 0, 0, 1, 0);
    cyc("pr_puck_over", 5, 5, 1, 1, 1, .want(32'hFFD700));

    // wr_sel=3 must not move anything.
    cyc("sel3_write", 0, 0, 0, 1, 1, 1, 3, 50, 50);
    cyc("sel3_vsync", 0, 0, 0, 1, 0);
    cyc("sel3_puck", 5, 5, 1, 1, 1, .want(32'hFFD700));
    cyc("sel3_bg", 50, 50, 1, 1, 1, .want(32'h004020));

    // Asynchronous reset mid-frame flushes the pipeline at once.
    cyc("mid_a", 5, 5, 1, 0, 1);
    cyc("mid_b", 5, 5, 1, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    q.delete();
    tq.delete();
    model_reset();
    hs_in = 1'b1; vs_in = 1'b1; visible_in = 1'b0; wr_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("mid_reset_hold");
    reset = 1'b0;
    cyc("post_reset_puck", 400, 240, 1, 1, 1, .want(32'hFFD700));
    cyc("post_reset_a", 100, 240, 1, 1, 1, .want(32'hE02020));
    repeat (3) cyc("drain", 0, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
